// File: rtl/id_seg.sv
// rtl/id_seg.sv - instruction decode segment: register file, immediate extension, load-use hazard, ID/EX register
module id_seg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IRi,
  input  logic [31:0] NPCi,
  input  logic        WBen,
  input  logic [4:0]  WBaddr,
  input  logic [31:0] WBdata,
  input  logic        flush,
  output logic [31:0] IRo,
  output logic [31:0] NPCo,
  output logic [31:0] Ao,
  output logic [31:0] Bo,
  output logic [31:0] Immo,
  output logic        stall
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [31:0] r_rf [0:31];
  logic [31:0] r_ir, r_npc, r_a, r_b, r_imm;

  logic [5:0]  w_op;
  logic [4:0]  w_rs, w_rt, w_ld_rt;
  logic [31:0] w_a, w_b, w_imm;
  logic        w_uses_rt, w_hazard, w_bubble, w_wr;

  assign w_op    = IRi[31:26];
  assign w_rs    = IRi[25:21];
  assign w_rt    = IRi[20:16];
  assign w_ld_rt = r_ir[20:16];
  assign w_wr    = WBen && (WBaddr != 5'd0);

  // Reads see a same-cycle write-back so the write-back stage needs no extra forwarding path
  assign w_a = (w_rs == 5'd0) ? 32'd0 : (w_wr && WBaddr == w_rs) ? WBdata : r_rf[w_rs];
  assign w_b = (w_rt == 5'd0) ? 32'd0 : (w_wr && WBaddr == w_rt) ? WBdata : r_rf[w_rt];

  always_comb begin
    w_imm = {16'h0000, IRi[15:0]};
    case (w_op)
      OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE:
        w_imm = {{16{IRi[15]}}, IRi[15:0]};
      OP_ANDI, OP_ORI, OP_XORI, OP_RTYPE:
        w_imm = {16'h0000, IRi[15:0]};
      OP_LUI:
        w_imm = {IRi[15:0], 16'h0000};
      OP_J, OP_JAL:
        w_imm = {6'b000000, IRi[25:0]};
      default:
        w_imm = {16'h0000, IRi[15:0]};
    endcase
  end

  // rt is a source operand only for R-type, stores and compare branches
  assign w_uses_rt = (w_op == OP_RTYPE) || (w_op == OP_SW) || (w_op == OP_BEQ) || (w_op == OP_BNE);

  assign w_hazard = (IRi != 32'd0) && (r_ir[31:26] == OP_LW) && (w_ld_rt != 5'd0) &&
                    ((w_ld_rt == w_rs) || (w_uses_rt && (w_ld_rt == w_rt)));

  assign stall    = w_hazard && !flush;
  assign w_bubble = flush || w_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    end else if (w_wr) begin
      r_rf[WBaddr] <= WBdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir  <= 32'd0;
      r_npc <= 32'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_imm <= 32'd0;
    end else if (w_bubble) begin
      r_ir  <= 32'd0;
      r_npc <= 32'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_imm <= 32'd0;
    end else begin
      r_ir  <= IRi;
      r_npc <= NPCi;
      r_a   <= w_a;
      r_b   <= w_b;
      r_imm <= w_imm;
    end
  end

  assign IRo  = r_ir;
  assign NPCo = r_npc;
  assign Ao   = r_a;
  assign Bo   = r_b;
  assign Immo = r_imm;

endmodule

// File: tb/tb_id_seg.sv
// tb/tb_id_seg.sv - scoreboard bench for id_seg with directed decode vectors
module tb_id_seg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IRi, NPCi, WBdata;
  logic        WBen, flush;
  logic [4:0]  WBaddr;
  logic [31:0] IRo, NPCo, Ao, Bo, Immo;
  logic        stall;

  id_seg dut (
    .clk(clk), .rst(rst), .IRi(IRi), .NPCi(NPCi),
    .WBen(WBen), .WBaddr(WBaddr), .WBdata(WBdata), .flush(flush),
    .IRo(IRo), .NPCo(NPCo), .Ao(Ao), .Bo(Bo), .Immo(Immo), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ir, npc, a, b, imm;
    logic        st;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(string n, logic [31:0] ir, logic [31:0] npc, logic [31:0] a,
                              logic [31:0] b, logic [31:0] imm, logic st);
    exp_t e;
    e.name = n; e.ir = ir; e.npc = npc; e.a = a; e.b = b; e.imm = imm; e.st = st;
    return e;
  endfunction

  task automatic step(input logic [31:0] ir, input logic [31:0] npc, input logic wen,
                      input logic [4:0] wa, input logic [31:0] wd, input logic fl, input exp_t e);
    @(negedge clk);
    IRi = ir; NPCi = npc; WBen = wen; WBaddr = wa; WBdata = wd; flush = fl;
    q.push_back(e);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, ".IRo"}, IRo, 32'd0);
    chk({tag, ".NPCo"}, NPCo, 32'd0);
    chk({tag, ".Ao"}, Ao, 32'd0);
    chk({tag, ".Bo"}, Bo, 32'd0);
    chk({tag, ".Immo"}, Immo, 32'd0);
    chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
  endtask

  // Monitor: stall is sampled mid-cycle with inputs settled, outputs just after the edge
  initial begin
    logic s_stall;
    exp_t e;
    forever begin
      @(negedge clk);
      #2 s_stall = stall;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.name, ".stall"}, {31'd0, s_stall}, {31'd0, e.st});
        chk({e.name, ".IRo"}, IRo, e.ir);
        chk({e.name, ".NPCo"}, NPCo, e.npc);
        chk({e.name, ".Ao"}, Ao, e.a);
        chk({e.name, ".Bo"}, Bo, e.b);
        chk({e.name, ".Immo"}, Immo, e.imm);
      end
    end
  end

  initial begin
    rst = 1'b0; IRi = 0; NPCi = 0; WBen = 0; WBaddr = 0; WBdata = 0; flush = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    step(32'h0, 32'h0, 1, 5'd1, 32'd1, 0, mk("wb1", 0, 0, 0, 0, 0, 0));
    step(32'h0, 32'h0, 1, 5'd3, 32'd3, 0, mk("wb3", 0, 0, 0, 0, 0, 0));
    step(32'h00231020, 32'h104, 0, 0, 0, 0, mk("add", 32'h00231020, 32'h104, 1, 3, 32'h1020, 0));
    step(32'h00A00020, 32'h108, 1, 5'd5, 32'hDEADBEEF, 0,
         mk("bypass", 32'h00A00020, 32'h108, 32'hDEADBEEF, 0, 32'h20, 0));
    step(32'h2001FFFF, 32'h10C, 0, 0, 0, 0, mk("addi", 32'h2001FFFF, 32'h10C, 0, 1, 32'hFFFFFFFF, 0));
    step(32'h3401FFFF, 32'h110, 0, 0, 0, 0, mk("ori", 32'h3401FFFF, 32'h110, 0, 1, 32'h0000FFFF, 0));
    step(32'h3C011234, 32'h114, 0, 0, 0, 0, mk("lui", 32'h3C011234, 32'h114, 0, 1, 32'h12340000, 0));
    step(32'h08000010, 32'h118, 0, 0, 0, 0, mk("j", 32'h08000010, 32'h118, 0, 0, 32'h10, 0));
    // load-use on rs: one stall cycle, bubble, then the add re-decodes
    step(32'h8C040000, 32'h200, 0, 0, 0, 0, mk("lw1", 32'h8C040000, 32'h200, 0, 0, 0, 0));
    step(32'h00853020, 32'h204, 0, 0, 0, 0, mk("hz_rs", 0, 0, 0, 0, 0, 1));
    step(32'h00853020, 32'h204, 0, 0, 0, 0, mk("redecode", 32'h00853020, 32'h204, 0, 32'hDEADBEEF, 32'h3020, 0));
    // flush beats the hazard
    step(32'h8C040000, 32'h300, 0, 0, 0, 0, mk("lw2", 32'h8C040000, 32'h300, 0, 0, 0, 0));
    step(32'h00853020, 32'h304, 0, 0, 0, 1, mk("flush", 0, 0, 0, 0, 0, 0));
    // hazard via rt on a store
    step(32'h8C040000, 32'h400, 0, 0, 0, 0, mk("lw3", 32'h8C040000, 32'h400, 0, 0, 0, 0));
    step(32'hAC240000, 32'h404, 0, 0, 0, 0, mk("hz_sw", 0, 0, 0, 0, 0, 1));
    step(32'hAC240000, 32'h404, 0, 0, 0, 0, mk("sw", 32'hAC240000, 32'h404, 1, 0, 0, 0));
    // ori's rt is a destination, so no hazard
    step(32'h8C040000, 32'h500, 0, 0, 0, 0, mk("lw4", 32'h8C040000, 32'h500, 0, 0, 0, 0));
    step(32'h34040005, 32'h504, 0, 0, 0, 0, mk("ori_rt", 32'h34040005, 32'h504, 0, 0, 32'h5, 0));
    // lw to $0 never hazards
    step(32'h8C000000, 32'h600, 0, 0, 0, 0, mk("lw0", 32'h8C000000, 32'h600, 0, 0, 0, 0));
    step(32'h00000020, 32'h604, 0, 0, 0, 0, mk("after_lw0", 32'h00000020, 32'h604, 0, 0, 32'h20, 0));
    // writes to $0 are dropped, including the bypass
    step(32'h0, 32'h0, 1, 5'd0, 32'd7, 0, mk("wb0", 0, 0, 0, 0, 0, 0));
    step(32'h00000020, 32'h700, 1, 5'd0, 32'd7, 0, mk("rd0", 32'h00000020, 32'h700, 0, 0, 32'h20, 0));
    step(32'h00231020, 32'h800, 0, 0, 0, 0, mk("pre_rst", 32'h00231020, 32'h800, 1, 3, 32'h1020, 0));

    // asynchronous reset pulse between edges, with a pending write that must be lost
    @(negedge clk);
    IRi = 32'h0; NPCi = 32'h0; WBen = 1; WBaddr = 5'd1; WBdata = 32'h55;
    #1 rst = 1'b0;
    #1 check_all_zero("mid_rst");
    WBen = 0;
    #1 rst = 1'b1;

    step(32'h00231020, 32'h900, 0, 0, 0, 0, mk("post_rst", 32'h00231020, 32'h900, 0, 0, 32'h1020, 0));

    @(negedge clk);
    IRi = 0; NPCi = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_seg.md
ID_SEG -- requirements
Module: id_seg

Interface
REQ-001 SHALL provide port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL provide port rst, input, 1, asynchronous active-low reset; rst=0 clears all state immediately, independent of clk.
REQ-003 SHALL provide port IRi, input, 32, instruction word from fetch segment.
REQ-004 SHALL provide port NPCi, input, 32, PC+4 of IRi from fetch segment.
REQ-005 SHALL provide port WBen, input, 1, register-file write enable from write-back.
REQ-006 SHALL provide port WBaddr, input, 5, write-back destination register.
REQ-007 SHALL provide port WBdata, input, 32, write-back data.
REQ-008 SHALL provide port flush, input, 1, squash current decode (taken branch/jump).
REQ-009 SHALL provide outputs IRo, NPCo, Ao, Bo, Immo, each 32 bits, registered, driving execute-segment inputs IRi, NPCi, Ai, Bi, Immi.
REQ-010 SHALL provide output stall, output, 1, combinational load-use hazard flag; fetch holds PC and IRi while 1.

Function
REQ-011 SHALL hold a 32x32 register file; reg 0 reads 0 always, writes to reg 0 ignored.
REQ-012 SHALL write WBdata to reg[WBaddr] on rising clk when WBen=1 and WBaddr!=0.
REQ-013 SHALL read rs=IRi[25:21], rt=IRi[20:16] combinationally; if WBen=1, WBaddr!=0 and WBaddr equals the read index, SHALL return WBdata (write-through bypass).
REQ-014 SHALL form Immo: sign-extend IRi[15:0] for opcodes addi 001000, slti 001010, lw 100011, sw 101011, beq 000100, bne 000101; zero-extend for andi 001100, ori 001101, xori 001110; {IRi[15:0],16'h0} for lui 001111; {6'b0,IRi[25:0]} for j 000010/jal 000011; zero-extend for R-type (opcode 000000).
REQ-015 SHALL detect load-use hazard when IRo opcode=100011, IRo[20:16]!=0, and IRo[20:16] equals IRi rs, or equals IRi rt where IRi is R-type, sw, beq or bne.
REQ-016 SHALL assert stall combinationally during a hazard; on that clock edge SHALL load a bubble (IRo=0, NPCo=0, Ao=0, Bo=0, Immo=0) so the dependent instruction re-decodes next cycle.
REQ-017 SHALL, on flush=1 at a rising edge, load the bubble regardless of hazard; stall SHALL be forced 0 while flush=1.
REQ-018 SHALL otherwise latch IRo=IRi, NPCo=NPCi, Ao=rs value, Bo=rt value, Immo=extended immediate at each rising edge; latency one cycle.
REQ-019 SHALL apply priority rst > flush > hazard > normal.
REQ-020 SHALL treat IRi=0 (sll $0,$0,0) as NOP; it never triggers hazard.

Reset
REQ-021 SHALL, while rst=0, force IRo, NPCo, Ao, Bo, Immo to 0 and all 32 registers to 0 asynchronously.
REQ-022 SHALL drive stall=0 during reset and for the first edge after release, since IRo=0.
REQ-023 SHALL, on reset asserted mid-operation, discard any pending WBen write in that cycle.

Verification
REQ-024 Bench SHALL write reg1=1, reg3=3 via WB, then IRi=0x00231020 (add $2,$1,$3) -> after one edge Ao=1, Bo=3, IRo=0x00231020.
REQ-025 Bench SHALL present WBen=1, WBaddr=5, WBdata=0xDEADBEEF with IRi reading rs=5 same cycle -> Ao=0xDEADBEEF next edge.
REQ-026 Bench SHALL issue IRi=0x2001FFFF (addi, imm 0xFFFF) -> Immo=0xFFFFFFFF; IRi=0x3401FFFF (ori) -> Immo=0x0000FFFF; IRi=0x3C011234 (lui) -> Immo=0x12340000.
REQ-027 Bench SHALL issue lw $4,0($0) (0x8C040000) then add $6,$4,$5 -> stall=1 one cycle, IRo=0 after second edge, add appears in IRo after third edge.
REQ-028 Bench SHALL assert flush=1 with a hazard present -> stall=0, IRo=0 next edge.
REQ-029 Bench SHALL write WBaddr=0, WBdata=7 then read rs=0 -> Ao=0; pulse rst=0 between edges -> all outputs 0 before next clk edge.
